// File: rtl/tile_seq_ctrl_if.sv
// Plotter-side bus of the tile sequencer: playback request in, pixel stream and status out.
interface tile_seq_if;
  logic        start;
  logic [17:0] seq;
  logic [3:0]  level;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;
  logic [3:0]  tile_idx;

  modport master (
    output start, seq, level,
    input  x, y, colour, plot, busy, done, tile_idx
  );

  modport slave (
    input  start, seq, level,
    output x, y, colour, plot, busy, done, tile_idx
  );
endinterface

// File: rtl/tile_seq_ctrl.sv
// Plays back up to nine 8x8 coloured tiles: draw, hold lit, erase, blank gap, per tile.
// Every output is a registered image of the state held during the previous cycle.
module tile_seq_ctrl #(
  parameter int HOLD_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 6_250_000
) (
  input  logic      clk,
  input  logic      resetn,
  tile_seq_if.slave bus
);

  localparam int MAX_DLY = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int DLY_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
  localparam logic [DLY_W-1:0] HOLD_LAST = DLY_W'(HOLD_CYCLES - 1);
  localparam logic [DLY_W-1:0] GAP_LAST  = DLY_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, HOLD, ERASE, GAP, DONE} state_t;

  state_t           state_q;
  logic [17:0]      seq_q;
  logic [3:0]       lvl_q;
  logic [3:0]       tile_q;
  logic [5:0]       pix_q;
  logic [DLY_W-1:0] dly_q;
  logic             bx_q;
  logic             by_q;
  logic [2:0]       tcol_q;

  logic [7:0] x_q, y_q;
  logic [2:0] colour_q;
  logic       plot_q, busy_q, done_q;
  logic [3:0] tidx_q;

  logic [3:0] lvl_eff;
  logic [1:0] code;
  logic [7:0] x_d, y_d;
  logic [2:0] colour_d;
  logic       plot_d;

  always_comb begin
    lvl_eff  = (bus.level > 4'd9) ? 4'd9 : bus.level;
    code     = {seq_q[{tile_q, 1'b0}], seq_q[{tile_q, 1'b1}]};
    plot_d   = (state_q == DRAW) || (state_q == ERASE);
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    if (plot_d) begin
      // Bases are 0 or 8, so base + p[2:0] never carries: the base is just bit 3.
      x_d      = {4'd0, bx_q, pix_q[2:0]};
      y_d      = {4'd0, by_q, pix_q[5:3]};
      colour_d = (state_q == DRAW) ? tcol_q : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      seq_q    <= '0;
      lvl_q    <= '0;
      tile_q   <= '0;
      pix_q    <= '0;
      dly_q    <= '0;
      bx_q     <= 1'b0;
      by_q     <= 1'b0;
      tcol_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tidx_q   <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= (state_q != IDLE);
      done_q   <= (state_q == DONE);
      tidx_q   <= tile_q;

      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            seq_q   <= bus.seq;
            lvl_q   <= lvl_eff;
            tile_q  <= '0;
            state_q <= (lvl_eff == 4'd0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          bx_q    <= code[0];
          by_q    <= code[1];
          tcol_q  <= {1'b0, code} + 3'd1;
          pix_q   <= '0;
          state_q <= DRAW;
        end
        DRAW: begin
          pix_q <= pix_q + 6'd1;
          if (pix_q == 6'd63) state_q <= HOLD;
        end
        HOLD: begin
          if (dly_q == HOLD_LAST) begin
            dly_q   <= '0;
            state_q <= ERASE;
          end else begin
            dly_q <= dly_q + DLY_W'(1);
          end
        end
        ERASE: begin
          pix_q <= pix_q + 6'd1;
          if (pix_q == 6'd63) state_q <= GAP;
        end
        GAP: begin
          if (dly_q == GAP_LAST) begin
            dly_q <= '0;
            if (tile_q + 4'd1 < lvl_q) begin
              tile_q  <= tile_q + 4'd1;
              state_q <= LOAD;
            end else begin
              state_q <= DONE;
            end
          end else begin
            dly_q <= dly_q + DLY_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tile_idx = tidx_q;

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Randomised bench for tile_seq_ctrl: a per-cycle expected-output trace built from the
// playback rules is compared against the DUT every cycle, plus literal spot checks.
module tb_tile_seq_ctrl;
  localparam int H    = 4;
  localparam int G    = 2;
  localparam int TILE = 1 + 64 + H + 64 + G;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  tile_seq_if bus();

  tile_seq_ctrl #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy;
    logic       plot;
    logic       done;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] col;
    logic [3:0] tidx;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input int b, input int p, input int d, input int xx,
                              input int yy, input int c, input int t);
    rec_t r;
    r.busy = (b != 0);
    r.plot = (p != 0);
    r.done = (d != 0);
    r.x    = 8'(xx);
    r.y    = 8'(yy);
    r.col  = 3'(c);
    r.tidx = 4'(t);
    return r;
  endfunction

  function automatic int eff_of(input logic [3:0] lv);
    return (lv > 4'd9) ? 9 : int'(lv);
  endfunction

  // Appends the whole expected cycle-by-cycle playback of one run to the trace.
  task automatic build(input logic [17:0] s, input int eff);
    logic [1:0] code;
    int bx, by, col;
    if (eff == 0) begin
      q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
      return;
    end
    for (int k = 0; k < eff; k++) begin
      code = {s[2*k], s[2*k+1]};
      case (code)
        2'b00:   begin bx = 0; by = 0; col = 1; end
        2'b01:   begin bx = 8; by = 0; col = 2; end
        2'b10:   begin bx = 0; by = 8; col = 3; end
        default: begin bx = 8; by = 8; col = 4; end
      endcase
      q.push_back(mk(1, 0, 0, 0, 0, 0, k));
      for (int p = 0; p < 64; p++) q.push_back(mk(1, 1, 0, bx + p % 8, by + p / 8, col, k));
      for (int i = 0; i < H; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, k));
      for (int p = 0; p < 64; p++) q.push_back(mk(1, 1, 0, bx + p % 8, by + p / 8, 0, k));
      for (int i = 0; i < G; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, k));
    end
    q.push_back(mk(1, 0, 1, 0, 0, 0, eff - 1));
  endtask

  // Outputs seen after an edge are the image of the cycle that edge ends.
  initial begin : model
    rec_t e;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        q.delete();
        cur = mk(0, 0, 0, 0, 0, 0, 0);
        e   = cur;
      end else begin
        e = cur;
        if (!cur.busy && bus.start) build(bus.seq, eff_of(bus.level));
        if (q.size() > 0) cur = q.pop_front();
        else              cur = mk(0, 0, 0, 0, 0, 0, 0);
      end
      #1;
      check("busy", 32'(bus.busy), 32'(e.busy));
      check("done", 32'(bus.done), 32'(e.done));
      check("plot", 32'(bus.plot), 32'(e.plot));
      if (e.busy) check("tile_idx", 32'(bus.tile_idx), 32'(e.tidx));
      if (e.plot) begin
        check("x", 32'(bus.x), 32'(e.x));
        check("y", 32'(bus.y), 32'(e.y));
        check("colour", 32'(bus.colour), 32'(e.col));
      end
    end
  end

  task automatic run(input logic [17:0] s, input logic [3:0] lv, input int poke_at,
                     output int lat, output int nbusy, output int nplot, output int nerase);
    @(negedge clk);
    bus.seq   = s;
    bus.level = lv;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; nbusy = 0; nplot = 0; nerase = 0;
    for (int i = 1; i <= 9 * TILE + 20 && lat < 0; i++) begin
      @(posedge clk);
      #2;
      if (bus.busy) nbusy++;
      if (bus.plot) nplot++;
      if (bus.plot && bus.colour == 3'd0) nerase++;
      if (bus.done) lat = i;
      if (i == poke_at) begin
        bus.start = 1'b1;
        bus.seq   = 18'($urandom);
        bus.level = 4'($urandom);
      end else if (i == poke_at + 1) begin
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, nb, np, ne, eff;
    logic [17:0] s;
    logic [3:0]  lv;
    bus.start = 1'b0;
    bus.seq   = '0;
    bus.level = '0;
    #1 resetn = 1'b0;
    #1;
    check("rst_plot", 32'(bus.plot), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_tile_idx", 32'(bus.tile_idx), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    run(18'h00001, 4'd1, -5, lat, nb, np, ne);
    check("single_done_lat", 32'(lat), 32'd136);
    check("single_busy", 32'(nb), 32'd136);
    check("single_plots", 32'(np), 32'd128);
    check("single_erase", 32'(ne), 32'd64);

    run(18'h27A5C, 4'd9, -5, lat, nb, np, ne);
    check("full_done_lat", 32'(lat), 32'd1216);
    check("full_busy", 32'(nb), 32'd1216);
    check("full_plots", 32'(np), 32'd1152);

    run(18'h15555, 4'd0, -5, lat, nb, np, ne);
    check("lvl0_done_lat", 32'(lat), 32'd1);
    check("lvl0_busy", 32'(nb), 32'd1);
    check("lvl0_plots", 32'(np), 32'd0);

    run(18'h3A0F1, 4'd12, -5, lat, nb, np, ne);
    check("lvl12_busy", 32'(nb), 32'd1216);

    run(18'h1B2C3, 4'd3, 67, lat, nb, np, ne);
    check("hold_restart_lat", 32'(lat), 32'd406);

    // start held high while resetn releases
    @(negedge clk);
    resetn = 1'b0; bus.start = 1'b1; bus.seq = 18'h00002; bus.level = 4'd1;
    @(posedge clk);
    @(negedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    @(negedge clk) bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 300 && lat < 0; i++) begin
      @(posedge clk);
      #2;
      if (bus.done) lat = i;
    end
    check("start_at_release_lat", 32'(lat), 32'd136);

    // reset during DRAW pixel 30 of tile 0 (code 11: base 8,8 colour 4)
    @(negedge clk);
    bus.seq = 18'h00003; bus.level = 4'd2; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk) bus.start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    check("px29_plot", 32'(bus.plot), 32'd1);
    check("px29_x", 32'(bus.x), 32'd13);
    check("px29_y", 32'(bus.y), 32'd11);
    check("px29_colour", 32'(bus.colour), 32'd4);
    #1 resetn = 1'b0;
    #1;
    check("abort_plot", 32'(bus.plot), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_x", 32'(bus.x), 32'd0);
    check("abort_y", 32'(bus.y), 32'd0);
    check("abort_colour", 32'(bus.colour), 32'd0);
    check("abort_tile_idx", 32'(bus.tile_idx), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      check("post_abort_plot", 32'(bus.plot), 32'd0);
      check("post_abort_done", 32'(bus.done), 32'd0);
    end
    run(18'($urandom), 4'd1, -5, lat, nb, np, ne);
    check("replay_done_lat", 32'(lat), 32'd136);

    for (int r = 0; r < 6; r++) begin
      s   = 18'($urandom);
      lv  = 4'($urandom_range(0, 15));
      eff = eff_of(lv);
      run(s, lv, -5, lat, nb, np, ne);
      check("rand_done_lat", 32'(lat), 32'((eff == 0) ? 1 : eff * TILE + 1));
      check("rand_plots", 32'(np), 32'(eff * 128));
      check("rand_erase", 32'(ne), 32'(eff * 64));
    end

    repeat (3) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
